// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and index helpers for the lane-combining mux family.
package mux_pkg;

    localparam int MODE_TDM  = 0;
    localparam int MODE_SKIP = 1;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N     = 4;

    // A selector always needs at least one bit, even for a degenerate lane count.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_lane_hold.sv
// rtl/mux_lane_hold.sv - one-deep hold buffer for a single input lane with sticky overrun flag.
module mux_lane_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    input  logic             i_drain,
    output logic [WIDTH-1:0] o_hold,
    output logic             o_occ,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_hold;
    logic             r_occ;
    logic             r_overflow;
    logic             w_load;
    logic             w_overrun;

    // A drain frees the slot on the same edge, so a back-to-back word is accepted.
    assign w_load    = i_valid && (!r_occ || i_drain);
    assign w_overrun = i_valid && r_occ && !i_drain;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold     <= '0;
            r_occ      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_hold <= i_data;
                r_occ  <= 1'b1;
            end else if (i_drain) begin
                r_occ  <= 1'b0;
            end
            if (w_overrun) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_hold     = r_hold;
    assign o_occ      = r_occ;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/mux_nx1_tdm.sv
// rtl/mux_nx1_tdm.sv - N:1 TDM / work-conserving lane mux; MUXTDM_LANE_ID_EN adds the lane_id output.
module mux_nx1_tdm
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int SKIP  = MODE_TDM
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   Entrada,
    input  logic [N-1:0]         validEntrada,
    output logic [WIDTH-1:0]     Salida,
    output logic                 validsalida,
    output logic [N-1:0]         overflow
`ifdef MUXTDM_LANE_ID_EN
    ,
    output logic [idx_width(N)-1:0] lane_id
`endif
);

    localparam int SW = idx_width(N);

    logic [SW-1:0]    r_slot;
    logic [SW-1:0]    w_slot_nxt;
    logic [SW-1:0]    w_grant;
    logic             w_grant_vld;
    logic [N-1:0]     w_occ;
    logic [N-1:0]     w_drain;
    logic [WIDTH-1:0] w_hold [N];
    logic [WIDTH-1:0] r_salida;
    logic             r_valid;

    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return SW'(s);
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        mux_lane_hold #(
            .WIDTH(WIDTH)
        ) u_hold (
            .clk       (clk),
            .reset     (reset),
            .i_data    (Entrada[gi*WIDTH +: WIDTH]),
            .i_valid   (validEntrada[gi]),
            .i_drain   (w_drain[gi]),
            .o_hold    (w_hold[gi]),
            .o_occ     (w_occ[gi]),
            .o_overflow(overflow[gi])
        );
    end

    always_comb begin
        w_grant     = r_slot;
        w_grant_vld = 1'b0;
        w_slot_nxt  = r_slot;
        if (SKIP == MODE_SKIP) begin
            // Scan from the far end back so the nearest occupied lane wins last.
            for (int k = N - 1; k >= 0; k--) begin
                if (w_occ[wrap_add(r_slot, k)]) begin
                    w_grant     = wrap_add(r_slot, k);
                    w_grant_vld = 1'b1;
                end
            end
            if (w_grant_vld) begin
                w_slot_nxt = wrap_add(w_grant, 1);
            end
        end else begin
            w_grant_vld = w_occ[r_slot];
            w_slot_nxt  = wrap_add(r_slot, 1);
        end
    end

    always_comb begin
        w_drain = '0;
        if (w_grant_vld) begin
            w_drain[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot   <= '0;
            r_salida <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_slot  <= w_slot_nxt;
            r_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_salida <= w_hold[w_grant];
            end
        end
    end

    assign Salida      = r_salida;
    assign validsalida = r_valid;

`ifdef MUXTDM_LANE_ID_EN
    logic [SW-1:0] r_lane_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane_id <= '0;
        end else if (w_grant_vld) begin
            r_lane_id <= w_grant;
        end
    end

    assign lane_id = r_lane_id;
`endif

endmodule

// File: tb/tb_mux_nx1_tdm.sv
// tb/tb_mux_nx1_tdm.sv - bench for mux_nx1_tdm in TDM and SKIP modes against a rule-level model.
module tb_mux_nx1_tdm;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic [3:0]  vin;

    logic [7:0]  t_out, s_out;
    logic        t_vld, s_vld;
    logic [3:0]  t_ovf, s_ovf;
`ifdef MUXTDM_LANE_ID_EN
    logic [1:0]  t_lid, s_lid;
`endif

    int total;
    int bad;

    // Model state, index 0 = TDM instance, 1 = SKIP instance.
    logic [3:0] m_occ [2];
    logic [3:0] m_ovf [2];
    logic [7:0] m_hold [2][4];
    int         m_slot [2];
    logic [7:0] m_out [2];
    logic       m_vld [2];
    int         m_lid [2];

    mux_nx1_tdm #(.WIDTH(8), .N(4), .SKIP(0)) dut_tdm (
        .clk         (clk),
        .reset       (rst),
        .Entrada     (din),
        .validEntrada(vin),
        .Salida      (t_out),
        .validsalida (t_vld),
        .overflow    (t_ovf)
`ifdef MUXTDM_LANE_ID_EN
        ,
        .lane_id     (t_lid)
`endif
    );

    mux_nx1_tdm #(.WIDTH(8), .N(4), .SKIP(1)) dut_skip (
        .clk         (clk),
        .reset       (rst),
        .Entrada     (din),
        .validEntrada(vin),
        .Salida      (s_out),
        .validsalida (s_vld),
        .overflow    (s_ovf)
`ifdef MUXTDM_LANE_ID_EN
        ,
        .lane_id     (s_lid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int g;
            int ns;
            if (rst) begin
                m_occ[m]  = '0;
                m_ovf[m]  = '0;
                m_slot[m] = 0;
                m_out[m]  = '0;
                m_vld[m]  = 1'b0;
                m_lid[m]  = 0;
            end else begin
                g = -1;
                if (m == 0) begin
                    if (m_occ[m][m_slot[m]]) g = m_slot[m];
                    ns = (m_slot[m] + 1) % 4;
                end else begin
                    for (int k = 0; k < 4; k++)
                        if (g < 0 && m_occ[m][(m_slot[m] + k) % 4]) g = (m_slot[m] + k) % 4;
                    ns = (g < 0) ? m_slot[m] : (g + 1) % 4;
                end
                if (g >= 0) begin
                    m_out[m] = m_hold[m][g];
                    m_vld[m] = 1'b1;
                    m_lid[m] = g;
                end else begin
                    m_vld[m] = 1'b0;
                end
                for (int i = 0; i < 4; i++) begin
                    if (vin[i]) begin
                        if (!m_occ[m][i] || i == g) begin
                            m_hold[m][i] = din[i*8 +: 8];
                            m_occ[m][i]  = 1'b1;
                        end else begin
                            m_ovf[m][i] = 1'b1;
                        end
                    end else if (i == g) begin
                        m_occ[m][i] = 1'b0;
                    end
                end
                m_slot[m] = ns;
            end
        end
    endtask

    task automatic check_all();
        chk("tdm_valid", {31'd0, t_vld}, {31'd0, m_vld[0]});
        chk("tdm_out",   {24'd0, t_out}, {24'd0, m_out[0]});
        chk("tdm_ovf",   {28'd0, t_ovf}, {28'd0, m_ovf[0]});
        chk("skip_valid", {31'd0, s_vld}, {31'd0, m_vld[1]});
        chk("skip_out",   {24'd0, s_out}, {24'd0, m_out[1]});
        chk("skip_ovf",   {28'd0, s_ovf}, {28'd0, m_ovf[1]});
`ifdef MUXTDM_LANE_ID_EN
        chk("tdm_lid",  {30'd0, t_lid}, m_lid[0]);
        chk("skip_lid", {30'd0, s_lid}, m_lid[1]);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_tdm_slot(input int s);
        for (int n = 0; n < 8 && m_slot[0] != s; n++) tick();
        chk("wait_slot", m_slot[0], s);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int m = 0; m < 2; m++) begin
            m_occ[m] = '0; m_ovf[m] = '0; m_slot[m] = 0;
            m_out[m] = '0; m_vld[m] = 1'b0; m_lid[m] = 0;
            for (int i = 0; i < 4; i++) m_hold[m][i] = '0;
        end

        // Reset with random inputs present
        rst = 1'b1;
        din = $urandom;
        vin = 4'($urandom);
        tick();
        din = $urandom;
        vin = 4'($urandom);
        tick();
        chk("rst_out",  {24'd0, t_out}, 32'h00);
        chk("rst_vld",  {31'd0, t_vld}, 32'h0);
        chk("rst_ovf",  {28'd0, t_ovf}, 32'h0);
        chk("rst_sovf", {28'd0, s_ovf}, 32'h0);
        chk("rst_slot", {30'd0, dut_tdm.r_slot}, 32'h0);
        rst = 1'b0;
        vin = 4'b0000;

        // SKIP: lanes 1 and 3 loaded together while slot = 0
        din = 32'h3300_1100;
        vin = 4'b1010;
        tick();
        vin = 4'b0000;
        tick();
        chk("skip_first",  {24'd0, s_out}, 32'h11);
        chk("skip_first_v", {31'd0, s_vld}, 32'h1);
        tick();
        chk("skip_second",  {24'd0, s_out}, 32'h33);
        chk("skip_second_v", {31'd0, s_vld}, 32'h1);
        chk("skip_slot_wrap", {30'd0, dut_skip.r_slot}, 32'h0);
        for (int n = 0; n < 5; n++) tick();

        // TDM full load in the slot-3 cycle
        wait_tdm_slot(3);
        din = 32'hA3A2_A1A0;
        vin = 4'b1111;
        tick();
        vin = 4'b0000;
        chk("full_gap", {31'd0, t_vld}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("full_word",  {24'd0, t_out}, 32'hA0 + k);
            chk("full_valid", {31'd0, t_vld}, 32'h1);
        end
        tick();
        chk("full_end", {31'd0, t_vld}, 32'h0);
        chk("full_ovf", {28'd0, t_ovf}, 32'h0);
        for (int n = 0; n < 4; n++) tick();

        // TDM sparse: lane 2 only, loaded at slot 0
        wait_tdm_slot(0);
        din = 32'h0055_0000;
        vin = 4'b0100;
        tick();
        vin = 4'b0000;
        chk("sparse_l0", {31'd0, t_vld}, 32'h0);
        tick();
        chk("sparse_l1", {31'd0, t_vld}, 32'h0);
        tick();
        chk("sparse_l2",   {24'd0, t_out}, 32'h55);
        chk("sparse_l2_v", {31'd0, t_vld}, 32'h1);
        tick();
        chk("sparse_l3", {31'd0, t_vld}, 32'h0);
        for (int n = 0; n < 4; n++) tick();

        // Overrun on lane 0 while slot != 0
        wait_tdm_slot(1);
        din = 32'h0000_0001;
        vin = 4'b0001;
        tick();
        din = 32'h0000_0002;
        tick();
        vin = 4'b0000;
        chk("ovr_flag", {31'd0, t_ovf[0]}, 32'h1);
        tick();
        chk("ovr_gap", {31'd0, t_vld}, 32'h0);
        tick();
        chk("ovr_word",  {24'd0, t_out}, 32'h01);
        chk("ovr_valid", {31'd0, t_vld}, 32'h1);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("ovr_nodup", {31'd0, t_vld}, 32'h0);
            chk("ovr_sticky", {31'd0, t_ovf[0]}, 32'h1);
        end

        // Drain plus load on lane 1
        wait_tdm_slot(2);
        din = 32'h0000_6600;
        vin = 4'b0010;
        tick();
        vin = 4'b0000;
        tick();
        tick();
        din = 32'h0000_7700;
        vin = 4'b0010;
        tick();
        vin = 4'b0000;
        chk("dl_old",   {24'd0, t_out}, 32'h66);
        chk("dl_old_v", {31'd0, t_vld}, 32'h1);
`ifdef MUXTDM_LANE_ID_EN
        chk("dl_old_lid", {30'd0, t_lid}, 32'h1);
`endif
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("dl_gap", {31'd0, t_vld}, 32'h0);
        end
        tick();
        chk("dl_new",   {24'd0, t_out}, 32'h77);
        chk("dl_new_v", {31'd0, t_vld}, 32'h1);
        chk("dl_ovf",   {28'd0, t_ovf}, 32'h1);
`ifdef MUXTDM_LANE_ID_EN
        chk("dl_new_lid", {30'd0, t_lid}, 32'h1);
`endif

        // Randomized traffic with occasional mid-run reset
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            din = $urandom;
            vin = 4'($urandom) & 4'($urandom);
            tick();
        end
        rst = 1'b0;
        vin = 4'b0000;
        for (int n = 0; n < 6; n++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_nx1_tdm.md
# mux_nx1_tdm

Parametrised N:1 time-division multiplexer with per-lane one-deep hold buffers. It is the next generation of the lane-combining mux stage: it merges N valid-qualified byte lanes onto one output lane running on the fast clock. The block captures each lane's word when its valid is high and holds it until that lane is granted an output slot. It supports a fixed round-robin TDM mode and a work-conserving mode that skips idle lanes, and it flags lane overruns.

## Interface
- `WIDTH`, 8: data width per lane.
- `N`, 4: number of input lanes, ≥2.
- `SKIP`, 0: 0 = fixed TDM (one slot per lane per rotation); 1 = work-conserving (grant next occupied lane).

Ports:
- `clk`  in  1  single clock (fast-domain clock, e.g. clk_4f at the instantiating level); all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Entrada`  in  N*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- `validEntrada`  in  N  lane i word valid this cycle.
- `Salida`  out  WIDTH  registered output word.
- `validsalida`  out  1  registered; `Salida` valid this cycle.
- `overflow`  out  N  sticky per-lane overrun flag.

## Operation
- Per lane: hold register `hold[i]` plus occupied bit `occ[i]`.
- Selector `slot` has width clog2(N).
- Each cycle, the drain decision uses the registered `occ`/`slot`.
  - TDM mode:
    - Grant lane `slot` if `occ[slot]`.
    - `slot` increments every cycle, wrapping N-1 → 0, regardless of occupancy.
  - SKIP mode:
    - Grant the first occupied lane at or after `slot`, searching cyclically.
    - After a grant, `slot` becomes grant+1 mod N.
    - If no lane is occupied, `slot` is unchanged.
- On a grant of lane g:
  - Next edge: `Salida` ← `hold[g]`, `validsalida` ← 1.
  - `occ[g]` is cleared unless it is reloaded on the same edge.
- No grant: `validsalida` ← 0 and `Salida` holds its previous value.
- Load: if `validEntrada[i]` is high, then at the edge `hold[i]` ← lane i and `occ[i]` ← 1, provided `occ[i]`=0 or lane i is being drained that cycle.
- Simultaneous drain and load on the same lane: the old word goes out, the new word is stored, and no overflow is raised.
- Overrun: `validEntrada[i]` high while `occ[i]`=1 and lane i is not drained that cycle.
  - The new word is dropped and the held word is kept.
  - `overflow[i]` ← 1 and stays set until reset.
- Reset values: `Salida`=0, `validsalida`=0, `overflow`=0, all `occ`=0, `slot`=0.
- Reset mid-operation: all pending held words are discarded, with no output for them.
- Reset has priority over load and drain in the same cycle.

## Timing
- Input valid in cycle c → occupied in c+1 → earliest grant in c+1 → `validsalida` in c+2. Minimum latency is 2 cycles.
- TDM worst case: N+1 cycles from input valid to output valid.
- SKIP worst case with all lanes busy: N+1 cycles.
- Throughput: at most one word per cycle, and at most one word per lane per rotation in TDM.
- A lane may sustain valid every N cycles in TDM without overflow when its loads align with or follow its drain slot.
- Output is fully registered; there is no combinational path from inputs to outputs.

## Configuration
- `MUXTDM_LANE_ID_EN`
  - Defined: adds an output port `lane_id` of width clog2(N). It is registered together with `Salida` and gives the granted lane index. It holds its value when `validsalida`=0 and resets to 0.
  - Undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `mux_pkg`:
  - mode constants `MODE_TDM`=0 and `MODE_SKIP`=1;
  - slot/lane index width helper (clog2);
  - default `WIDTH`/`N` constants used across the mux family.
- Sub-module `mux_lane_hold`, one instance per lane (generate loop). It holds `hold`, `occ` and `overflow` for that lane. Inputs are data, valid, drain and reset.
- Top level contains the selector/arbiter and the output registers.

## Test plan
Benches use N=4, WIDTH=8.
1. Reset: hold `reset`=1 for 2 cycles with random inputs → `Salida`=0x00, `validsalida`=0, `overflow`=4'b0000; after release the first grant is lane 0.
2. TDM full load: lanes 0–3 = 0xA0,0xA1,0xA2,0xA3, all valid in the single cycle where `slot`=3 → `Salida` A0,A1,A2,A3 on 4 consecutive cycles starting 2 cycles later, `validsalida` high exactly 4 cycles, `overflow`=0.
3. TDM sparse: only lane 2 = 0x55, valid one cycle while `slot`=0 → 0x55 appears once, when lane 2's slot comes; `validsalida`=0 in the cycles for lanes 0, 1 and 3.
4. SKIP: `SKIP`=1, lanes 1=0x11 and 3=0x33 loaded together, `slot`=0 → 0x11 then 0x33 on back-to-back cycles, then `slot`=0.
5. Overflow: TDM mode, lane 0 valid with 0x01 then 0x02 in consecutive cycles while `slot`≠0 → only 0x01 is emitted, `overflow[0]`=1 and stays 1 until reset.
6. Drain plus load: lane 1 valid with 0x77 in the cycle its held 0x66 is granted → 0x66 out, then 0x77 out one rotation later, `overflow[1]`=0; with `MUXTDM_LANE_ID_EN` defined, `lane_id`=1 on both outputs.
